// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2:1 arbitrated mux: state encodings and defaults.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int DEF_W        = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/mux2to1_w.sv
// W-bit combinational 2:1 multiplexer feeding the arbiter's output register.
module mux2to1_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  // Select b when s is high, otherwise a.
  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/mux2to1_arb.sv
// Two-requester arbiter with a bounded hold time, driving a registered 2:1 mux.
// Ties from IDLE go to the requester not served last; an owner that keeps its
// request is pre-empted after MAX_HOLD cycles only if the other side waits.
module mux2to1_arb
  import mux_arb_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         s,
  output logic [W-1:0] y,
  output logic         valid
);

  localparam int            HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold;
  logic          last;
  logic          s_nxt;
  logic          granted;
  logic          entering;
  logic [W-1:0]  mux_y;

  assign gnt0     = (state == G0);
  assign gnt1     = (state == G1);
  assign granted  = gnt0 | gnt1;
  assign entering = (state_nxt != IDLE) && (state_nxt != state);

  // Next-state and next-select decision.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
        else               state_nxt = IDLE;
      end
      G0: begin
        if (!req0)                          state_nxt = req1 ? G1 : IDLE;
        else if (hold == HOLD_MAX && req1)  state_nxt = G1;
        else                                state_nxt = G0;
      end
      G1: begin
        if (!req1)                          state_nxt = req0 ? G0 : IDLE;
        else if (hold == HOLD_MAX && req0)  state_nxt = G0;
        else                                state_nxt = G1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == G0)      s_nxt = 1'b0;
    else if (state_nxt == G1) s_nxt = 1'b1;
  end

  mux2to1_w #(.W(W)) u_mux (
    .a (d0),
    .b (d1),
    .s (s_nxt),
    .y (mux_y)
  );

  // State, select, hold counter, last-served and the output data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= 1'b0;
      hold  <= '0;
      last  <= 1'b1;
      y     <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      if (entering) begin
        hold <= HW'(1);
        last <= s_nxt;
      end else if (state_nxt != IDLE) begin
        if (hold != HOLD_MAX) hold <= hold + HW'(1);
      end else begin
        hold <= '0;
      end
      y     <= granted ? mux_y : '0;
      valid <= granted;
    end
  end

endmodule

// File: doc/mux2to1_arb.md
MUX2TO1_ARB -- requirements
Module: mux2to1_arb

Interface
REQ-001 Parameter W, default 8, SHALL set the data width.
REQ-002 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive grant cycles while the other requester waits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req0  input  1  SHALL be the requester-0 access request, level-held.
REQ-006 req1  input  1  SHALL be the requester-1 access request, level-held.
REQ-007 d0  input  W  SHALL be the requester-0 data.
REQ-008 d1  input  W  SHALL be the requester-1 data.
REQ-009 gnt0  output  1  SHALL be the registered grant to requester 0.
REQ-010 gnt1  output  1  SHALL be the registered grant to requester 1.
REQ-011 s  output  1  SHALL be the registered mux select (0 = d0, 1 = d1); it holds its last value when idle.
REQ-012 y  output  W  SHALL be the registered muxed data.
REQ-013 valid  output  1  SHALL be high when y carries granted data.

Function
REQ-014 The FSM SHALL have states IDLE, G0 and G1; gnt0 = (state==G0) and gnt1 = (state==G1), and the two grants SHALL never both be high.
REQ-015 IDLE, one request pending: the FSM SHALL enter that grant state on the next edge (1-cycle request-to-grant latency).
REQ-016 IDLE, both requests pending: the FSM SHALL grant the requester that is not recorded in the last-served register.
REQ-017 On entry to G0 or G1, s SHALL be set to the grant index, last-served SHALL be updated, and the hold counter SHALL load 1.
REQ-018 While granted and the owner's request stays high, the hold counter SHALL increment each cycle and saturate at MAX_HOLD.
REQ-019 Owner request low and other request high: the FSM SHALL switch directly to the other grant on the next edge, with no IDLE bubble.
REQ-020 Owner request low and other request low: the FSM SHALL return to IDLE on the next edge.
REQ-021 Hold counter equal to MAX_HOLD and other request high: the FSM SHALL switch to the other grant on the next edge even if the owner still requests.
REQ-022 Hold counter equal to MAX_HOLD and other request low: the grant SHALL continue with the counter saturated.
REQ-023 Each cycle in G0/G1, y SHALL load d[s_next] and valid SHALL be 1, so y at edge k+1 equals the granted input sampled at edge k.
REQ-024 In IDLE, y SHALL be 0 and valid SHALL be 0.
REQ-025 The hold counter SHALL be clog2(MAX_HOLD+1) bits wide and SHALL never wrap.
REQ-026 A request asserted and dropped within one cycle while the other requester owns the grant SHALL be ignored.

Reset
REQ-027 While rst=1 at an edge, the block SHALL set state=IDLE, gnt0=gnt1=0, s=0, y=0, valid=0, hold counter=0 and last-served=1, so req0 wins the first tie.
REQ-028 Reset asserted mid-grant SHALL drop the grant at that edge regardless of the request inputs; there SHALL be no partial transfer afterwards.

Structure
REQ-029 State encodings (IDLE=2'd0, G0=2'd1, G1=2'd2) and the default W and MAX_HOLD values SHALL live in the shared package/include mux_arb_pkg.
REQ-030 The data path SHALL instantiate one sub-module, mux2to1_w (W-bit 2:1 mux, ports a, b, s, y), feeding the y register.
REQ-031 The unused state encoding SHALL recover to IDLE.

Verification
REQ-032 Bench SHALL cover: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0, y=0, valid=0; first edge after reset -> gnt0=1.
REQ-033 Bench SHALL cover: req0 only, d0=8'hA5, for 3 cycles -> gnt0=1 one cycle later; y=8'hA5 and valid=1 on the following edge; IDLE one cycle after req0 drops.
REQ-034 Bench SHALL cover: req0 and req1 held with MAX_HOLD=4 -> grants alternate G0x4, G1x4, G0x4; s toggles in step; no cycle has both grants.
REQ-035 Bench SHALL cover: G0 owned, req0 drops in the same cycle req1 rises -> G1 on the next edge, valid stays 1 and y switches to d1.
REQ-036 Bench SHALL cover: req1 alone for 10 cycles -> gnt1 stays high, counter saturates at 4, no drop to IDLE.
REQ-037 Bench SHALL cover: rst pulsed during G1 -> gnt1=0 and y=0 at that edge; after release with req0=req1=1, req0 wins.
